// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM states, operation codes, default width.
package seq_divider_pkg;

    localparam int N_DEFAULT = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    // funct3[1:0] encoding: bit0 selects unsigned, bit1 selects remainder
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shifts the next dividend bit into the partial
// remainder and keeps the n+1-bit trial difference when it does not go negative.
module div_step #(
    parameter int n = 32
) (
    input  logic [n-1:0] rem_i,
    input  logic         bit_i,
    input  logic [n-1:0] dvs_i,
    output logic [n-1:0] rem_o,
    output logic         q_o
);

    logic [n:0] trial;
    logic [n:0] diff;

    assign trial = {rem_i, bit_i};
    assign diff  = trial - {1'b0, dvs_i};
    assign q_o   = (trial >= {1'b0, dvs_i});
    // rem_i < dvs_i keeps a successful difference below dvs_i, so n bits suffice
    assign rem_o = q_o ? diff[n-1:0] : trial[n-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider (DIV/DIVU/REM/REMU), one quotient bit per
// cycle, with divide-by-zero and signed-overflow short cuts.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int n = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [n-1:0] result,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic         overflow
);

    localparam int CW = $clog2(n);
    localparam logic [n-1:0] MIN_NEG = {1'b1, {(n-1){1'b0}}};

    state_e         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [n-1:0]   a_q, a_d, b_q, b_d;
    logic [n-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, res_q, res_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, ov_q, ov_d;

    logic           is_signed, is_rem, zero_div, sgn_ovf;
    logic           step_q;
    logic [n-1:0]   step_rem;

    assign is_signed = ~op_q[0];
    assign is_rem    = op_q[1];
    assign zero_div  = (b_q == '0);
    assign sgn_ovf   = is_signed && (a_q == MIN_NEG) && (b_q == '1);

    div_step #(.n(n)) u_step (
        .rem_i (rem_q),
        .bit_i (quo_q[n-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_PREP;
            S_PREP: state_d = (zero_div || sgn_ovf) ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        res_d  = res_q;
        cnt_d  = cnt_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        ov_d   = ov_q;
        case (state_q)
            S_IDLE: if (start) begin
                op_d = op;
                a_d  = A;
                b_d  = B;
            end
            S_PREP: begin
                if (zero_div) begin
                    dz_d  = 1'b1;
                    ov_d  = 1'b0;
                    res_d = is_rem ? a_q : '1;
                end else if (sgn_ovf) begin
                    dz_d  = 1'b0;
                    ov_d  = 1'b1;
                    res_d = is_rem ? '0 : MIN_NEG;
                end else begin
                    // dividend is shifted out of quo_q while quotient bits shift in
                    quo_d  = (is_signed && a_q[n-1]) ? -a_q : a_q;
                    dvs_d  = (is_signed && b_q[n-1]) ? -b_q : b_q;
                    rem_d  = '0;
                    qneg_d = is_signed && (a_q[n-1] ^ b_q[n-1]);
                    rneg_d = is_signed && a_q[n-1];
                    cnt_d  = CW'(n - 1);
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[n-2:0], step_q};
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            S_FIX: begin
                dz_d = 1'b0;
                ov_d = 1'b0;
                if (is_rem) res_d = rneg_q ? -rem_q : rem_q;
                else        res_d = qneg_q ? -quo_q : quo_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            res_q  <= res_d;
            cnt_q  <= cnt_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
            ov_q   <= ov_d;
        end
    end

    assign result   = res_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign div_zero = dz_q;
    assign overflow = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (n=32): expectations queued at issue, checked on done.
module tb_seq_divider;

    localparam int N = 32;

    typedef struct {
        logic [N-1:0] res;
        logic         dz;
        logic         ov;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [N-1:0] result;
    logic         busy, done, div_zero, overflow;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           done_cnt = 0;
    logic [N-1:0] last_exp = '0;

    seq_divider #(.n(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .result(result), .busy(busy), .done(done),
        .div_zero(div_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got result=%h with nothing outstanding", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                last_exp = e.res;
                if ({result, div_zero, overflow} !== {e.res, e.dz, e.ov} || (cyc - acc_cyc) != e.lat) begin
                    n_fail++;
                    $display("FAIL done_check: got res=%h dz=%b ov=%b lat=%0d, want res=%h dz=%b ov=%b lat=%0d",
                             result, div_zero, overflow, cyc - acc_cyc, e.res, e.dz, e.ov, e.lat);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [N-1:0] r, input logic dz, input logic ov, input int lat);
        exp_t e;
        e.res = r; e.dz = dz; e.ov = ov; e.lat = lat;
        return e;
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        logic sg, rm;
        logic [N-1:0] r;
        sg = !o[0];
        rm = o[1];
        if (b == '0) return mk(rm ? a : '1, 1'b1, 1'b0, 1);
        if (sg && a == 32'h8000_0000 && b == '1) return mk(rm ? 32'h0 : 32'h8000_0000, 1'b0, 1'b1, 1);
        if (sg) begin
            if (rm) r = $signed(a) % $signed(b);
            else    r = $signed(a) / $signed(b);
        end else begin
            if (rm) r = a % b;
            else    r = a / b;
        end
        return mk(r, 1'b0, 1'b0, 34);
    endfunction

    task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                         input exp_t e, input bit push);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start = 1'b0;
        A = $urandom; B = $urandom; op = 2'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s_timeout: %0d results outstanding, want 0", tag, sb.size());
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({result, busy, done, div_zero, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got res=%h busy=%b done=%b dz=%b ov=%b, want all 0",
                     result, busy, done, div_zero, overflow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        issue(2'b00, 32'd100, 32'd7, mk(32'd14, 0, 0, 34), 1);
        wait_idle("div_100_7");
        issue(2'b10, 32'd100, 32'd7, mk(32'd2, 0, 0, 34), 1);
        wait_idle("rem_100_7");
        repeat (3) @(negedge clk);
        n_cmp++;
        if (result !== 32'd2) begin
            n_fail++;
            $display("FAIL result_hold: got %h, want %h", result, 32'd2);
        end
    endtask

    task automatic test_signed();
        issue(2'b00, -32'sd7, 32'd2, mk(32'hFFFF_FFFD, 0, 0, 34), 1);
        wait_idle("div_m7_2");
        issue(2'b10, -32'sd7, 32'd2, mk(32'hFFFF_FFFF, 0, 0, 34), 1);
        wait_idle("rem_m7_2");
        issue(2'b01, 32'hFFFF_FFFF, 32'd16, mk(32'h0FFF_FFFF, 0, 0, 34), 1);
        wait_idle("divu_max_16");
        issue(2'b11, 32'hFFFF_FFFF, 32'd16, mk(32'h0000_000F, 0, 0, 34), 1);
        wait_idle("remu_max_16");
    endtask

    task automatic test_special();
        issue(2'b00, 32'd5, 32'd0, mk(32'hFFFF_FFFF, 1, 0, 1), 1);
        wait_idle("div_zero");
        issue(2'b10, 32'd5, 32'd0, mk(32'd5, 1, 0, 1), 1);
        wait_idle("rem_zero");
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 0, 1, 1), 1);
        wait_idle("div_ovf");
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 0, 1, 1), 1);
        wait_idle("rem_ovf");
    endtask

    task automatic test_back_to_back();
        issue(2'b01, 32'd20, 32'd6, mk(32'd3, 0, 0, 34), 1);
        wait_idle("divu_20_6");
        // still inside the DONE cycle here: this start must be dropped
        start = 1'b1; op = 2'b01; A = 32'd9; B = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done: got busy=%b, want 0", busy);
        end
        issue(2'b11, 32'd20, 32'd6, mk(32'd2, 0, 0, 34), 1);
        wait_idle("remu_20_6");
    endtask

    task automatic test_ignore_start();
        int d0;
        d0 = done_cnt;
        issue(2'b00, 32'd1000, 32'd10, mk(32'd100, 0, 0, 34), 1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b1; op = 2'b01; A = $urandom; B = 32'd5;
            @(posedge clk);
            #1;
            start = 1'b0;
            n_cmp++;
            if (busy !== 1'b1 || result !== last_exp) begin
                n_fail++;
                $display("FAIL busy_start_%0d: got busy=%b res=%h, want busy=1 res=%h", i, busy, result, last_exp);
            end
        end
        wait_idle("ignore_start");
        repeat (40) @(negedge clk);
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL done_pulses: got %0d, want 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        issue(2'b01, 32'd1234, 32'd5, mk(32'd0, 0, 0, 0), 0);
        d0 = done_cnt;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({result, busy, done, div_zero, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got res=%h busy=%b done=%b dz=%b ov=%b, want all 0",
                     result, busy, done, div_zero, overflow);
        end
        repeat (40) @(negedge clk);
        n_cmp++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d pulses, want 0", done_cnt - d0);
        end
        rst_n = 1'b1;
        issue(2'b01, 32'd9, 32'd3, mk(32'd3, 0, 0, 34), 1);
        wait_idle("divu_after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [1:0]   o;
            logic [N-1:0] a, b;
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = '1; end
                2: b = 32'($urandom_range(1, 20));
                3: b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            issue(o, a, b, model(o, a, b), 1);
            wait_idle("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_special();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: n, 32, operand/result width in bits (n >= 4).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] encoding).
REQ-006 A  input  n  dividend; captured on the accepting edge.
REQ-007 B  input  n  divisor; captured on the accepting edge.
REQ-008 result  output  n  quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-009 busy  output  1  high from accepting edge until the DONE cycle ends.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 div_zero  output  1  flag: B == 0 for the last operation.
REQ-012 overflow  output  1  flag: signed DIV/REM with A = -2^(n-1), B = -1.

Function
REQ-013 FSM states SHALL be IDLE, PREP, CALC, FIX, DONE.
REQ-014 IDLE: start=1 -> PREP; A, B, op latched; busy=1 from that edge.
REQ-015 PREP: detect div_zero/overflow; signed ops take absolute values and record quotient/remainder signs; special case -> DONE, else -> CALC.
REQ-016 CALC: exactly n iterations of restoring division, one quotient bit per cycle, MSB first; trial subtraction n+1 bits wide; iteration counter counts n-1 down to 0, then -> FIX.
REQ-017 FIX: quotient negated if operand signs differ (signed only); remainder takes the dividend's sign; -> DONE.
REQ-018 DONE: done=1 for exactly one cycle, busy=0 after it; -> IDLE.
REQ-019 Latency: normal case, done high in the cycle after edge n+2 counted from the accepting edge (edge 0); special cases, after edge 1.
REQ-020 Divide by zero: quotient all ones, remainder = A, div_zero=1.
REQ-021 Signed overflow: quotient = -2^(n-1), remainder = 0, overflow=1.
REQ-022 result, div_zero, overflow SHALL update only in DONE and hold until the next DONE.
REQ-023 start while busy=1 SHALL be ignored; no queueing.
REQ-024 start in the DONE cycle SHALL be ignored; start in the first IDLE cycle after DONE is accepted.
REQ-025 Changes on A, B, op after acceptance SHALL have no effect.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, result=0, busy=0, done=0, div_zero=0, overflow=0, counter=0.
REQ-027 Reset mid-operation SHALL abandon the operation, with no done pulse; first start after release behaves normally.

Structure
REQ-028 Shared package: state encoding, op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU), default width 32.
REQ-029 One sub-module, div_step: combinational n+1-bit trial subtract producing the new partial remainder and quotient bit; instantiated once.

Verification (n=32)
REQ-030 DIV A=100, B=7 -> result=14, done after edge 34; REM same operands -> 2; flags 0.
REQ-031 DIV A=-7, B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU A=0xFFFFFFFF, B=16 -> 0x0FFFFFFF; REMU -> 0xF.
REQ-032 DIV A=5, B=0 -> 0xFFFFFFFF, div_zero=1, done after edge 1; REM -> 5.
REQ-033 DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000, overflow=1; REM -> 0.
REQ-034 start pulses during CALC with different A/B -> ignored; first result unchanged; exactly one done pulse.
REQ-035 rst_n low in CALC iteration 10 -> all outputs 0 at once, no done; after release, DIVU 9/3 -> 3.
